ret_addr_stack: RTL
===================

Name: ret_addr_stack

Overview:
Parametrised hardware return-address stack for the pipelined CPU; replaces the push/pop return-address storage currently embedded in reg_file. Written by ID-stage call instructions (push of pc+1) and read by ID-stage ret instructions. The top-of-stack is available combinationally so ret resolves in ID like branch/jump. Adds depth/width generics, full/empty status, overflow policy, sticky error flags and simultaneous push+pop.

Parameters:
ADDR_W, 8, width of stored return address (pc width)
DEPTH, 8, number of entries; power of two, >= 2
OVF_WRAP, 0, 0 = push when full is rejected; 1 = push when full overwrites oldest entry (circular)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
push  input  1  push push_addr this cycle (ID_push)
pop  input  1  pop top entry this cycle (ID_pop)
push_addr  input  ADDR_W  return address to store (ID_pc_plus_one)
top  output  ADDR_W  current top-of-stack, combinational from state; 0 when empty
empty  output  1  count == 0
full  output  1  count == DEPTH
count  output  $clog2(DEPTH)+1  valid entries
overflow  output  1  sticky: push rejected or oldest entry overwritten
underflow  output  1  sticky: pop while empty
err_clr  input  1  synchronous clear of overflow/underflow

Behaviour:
- State: storage array DEPTH x ADDR_W, write pointer wp ($clog2(DEPTH) bits, wraps modulo DEPTH), count.
- Reset (async, reset=1): wp=0, count=0, overflow=0, underflow=0; top=0, empty=1, full=0. Storage contents not reset. Reset mid-operation discards all entries immediately.
- top = storage[wp-1 mod DEPTH] when count>0, else 0. Updates on the clock edge after push/pop (latency 1).
- push only, not full: storage[wp]<=push_addr; wp+1; count+1.
- push only, full, OVF_WRAP=0: no state change; overflow<=1.
- push only, full, OVF_WRAP=1: storage[wp]<=push_addr; wp+1; count stays DEPTH; overflow<=1.
- pop only, count>0: wp-1; count-1. Entry not cleared.
- pop only, empty: no change; underflow<=1; top stays 0.
- push and pop same cycle, count>0: storage[wp-1]<=push_addr; wp and count unchanged (replace top). No flags set, including when full.
- push and pop same cycle, empty: treated as push only; underflow<=1.
- err_clr: clears both sticky flags at the edge; a new error in the same cycle wins (flag=1).
- empty/full/count are registered-state derived, with no combinational path from push/pop.

Optional Feature:
RAS_CHECKPOINT_EN: adds ports ckpt (in,1), restore (in,1). ckpt captures {wp,count} into a shadow register; restore reloads {wp,count} from the shadow on the next edge. Restore has priority over push/pop in the same cycle. The shadow resets to 0. This supports ID-stage flush on hazard redirect. Entries overwritten since ckpt are not recovered. Without the macro, the ports are absent and there is no shadow logic.

Decomposition:
- Shared cpu_pkg: PC_W=8 constant (default source for ADDR_W), stack opcode constants for push/pop/ret, and the {wp,count} checkpoint struct typedef.
- One sub-module, ras_storage: DEPTH x ADDR_W register array with one write port and one async read port, no reset. All pointer, flag and checkpoint logic stays in ret_addr_stack.

Test Plan:
- Reset, then push 0x11, 0x22, 0x33 -> top=0x33, count=3; pop -> top=0x22; pop x2 -> empty=1, top=0, underflow=0.
- DEPTH=8, OVF_WRAP=0: push 0x01..0x08, then push 0x09 -> full=1, top=0x08, overflow=1, count=8. Pop x8 returns 0x08..0x01 in order.
- DEPTH=8, OVF_WRAP=1: push 0x01..0x09 -> top=0x09, count=8, overflow=1. Pop x8 returns 0x09..0x02; then empty=1.
- Stack holding 0x40, 0x41: push+pop with 0x50 -> top=0x50, count=2. Then, from empty, push+pop with 0x60 -> top=0x60, count=1, underflow=1.
- Pop when empty -> underflow=1. err_clr with no new error -> underflow=0. Assert reset mid-sequence with 3 entries -> count=0 and top=0 without waiting for a clock edge.
- RAS_CHECKPOINT_EN: push 0x10, ckpt, push 0x20, pop, pop, then restore -> count=1, top=0x10. restore with push in the same cycle -> push ignored.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: pc width, return-address-stack opcodes and checkpoint payload.
package cpu_pkg;

    localparam int unsigned PC_W          = 8;
    localparam int unsigned RAS_PTR_MAX_W = 8;
    localparam int unsigned RAS_CNT_MAX_W = RAS_PTR_MAX_W + 1;

    // Stack operation decoded from {push, pop}; pop serves ret, push serves call.
    typedef enum logic [1:0] {
        STK_OP_NONE = 2'b00,
        STK_OP_POP  = 2'b01,
        STK_OP_PUSH = 2'b10,
        STK_OP_REPL = 2'b11
    } stk_op_e;

    // Checkpointed stack position, sized for stacks up to 2**RAS_PTR_MAX_W entries.
    typedef struct packed {
        logic [RAS_PTR_MAX_W-1:0] wp;
        logic [RAS_CNT_MAX_W-1:0] count;
    } ras_ckpt_t;

endpackage

// File: rtl/ras_storage.sv
// Return-address register array: one synchronous write port, one asynchronous read port, no reset.
module ras_storage #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 8,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [PTR_W-1:0]  waddr,
    input  logic [ADDR_W-1:0] wdata,
    input  logic [PTR_W-1:0]  raddr,
    output logic [ADDR_W-1:0] rdata
);

    logic [ADDR_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ret_addr_stack.sv
// Return-address stack for ID-stage call/ret with overflow policy and sticky error flags.
// Optional checkpoint/restore of the stack position is enabled with `define RAS_CHECKPOINT_EN.
module ret_addr_stack
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W   = PC_W,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned OVF_WRAP = 0,
    localparam int unsigned PTR_W   = $clog2(DEPTH),
    localparam int unsigned CNT_W   = PTR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic              err_clr,
`ifdef RAS_CHECKPOINT_EN
    input  logic              ckpt,
    input  logic              restore,
`endif
    output logic [ADDR_W-1:0] top,
    output logic              empty,
    output logic              full,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic              underflow
);

    logic [PTR_W-1:0]  wp;
    logic [PTR_W-1:0]  wp_top;
    logic [PTR_W-1:0]  wp_nxt;
    logic [CNT_W-1:0]  count_nxt;
    logic [PTR_W-1:0]  waddr;
    logic              we;
    logic              ovf_set;
    logic              unf_set;
    logic [ADDR_W-1:0] rd_data;
    stk_op_e           op;

    assign op     = stk_op_e'({push, pop});
    assign wp_top = wp - PTR_W'(1);
    assign empty  = (count == CNT_W'(0));
    assign full   = (count == CNT_W'(DEPTH));
    assign top    = empty ? ADDR_W'(0) : rd_data;

`ifdef RAS_CHECKPOINT_EN
    ras_ckpt_t shadow;

    // Shadow of the stack position for flush recovery.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow <= '0;
        end else if (ckpt) begin
            shadow <= '{wp: RAS_PTR_MAX_W'(wp), count: RAS_CNT_MAX_W'(count)};
        end
    end
`endif

    // Next pointer/count, storage write and error detection.
    always_comb begin
        wp_nxt    = wp;
        count_nxt = count;
        we        = 1'b0;
        waddr     = wp;
        ovf_set   = 1'b0;
        unf_set   = 1'b0;

        unique case (op)
            STK_OP_POP: begin
                if (empty) begin
                    unf_set = 1'b1;
                end else begin
                    wp_nxt    = wp_top;
                    count_nxt = count - CNT_W'(1);
                end
            end
            STK_OP_PUSH, STK_OP_REPL: begin
                if (op == STK_OP_REPL && !empty) begin
                    // Replace top in place: ret and call in the same cycle.
                    we    = 1'b1;
                    waddr = wp_top;
                end else begin
                    unf_set = (op == STK_OP_REPL);
                    if (!full) begin
                        we        = 1'b1;
                        wp_nxt    = wp + PTR_W'(1);
                        count_nxt = count + CNT_W'(1);
                    end else begin
                        ovf_set = 1'b1;
                        if (OVF_WRAP != 0) begin
                            we     = 1'b1;
                            wp_nxt = wp + PTR_W'(1);
                        end
                    end
                end
            end
            default: ;
        endcase

`ifdef RAS_CHECKPOINT_EN
        if (restore) begin
            wp_nxt    = PTR_W'(shadow.wp);
            count_nxt = CNT_W'(shadow.count);
            we        = 1'b0;
            ovf_set   = 1'b0;
            unf_set   = 1'b0;
        end
`endif
    end

    // Stack position and sticky error flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp        <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wp        <= wp_nxt;
            count     <= count_nxt;
            overflow  <= ovf_set | (overflow & ~err_clr);
            underflow <= unf_set | (underflow & ~err_clr);
        end
    end

    ras_storage #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_storage (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (push_addr),
        .raddr (wp_top),
        .rdata (rd_data)
    );

endmodule
